alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 48-bit registered ALU. It accepts one operation at a time over a valid/ready handshake, holds the operands registered while the ALU computes, and returns the result on a single backpressured response channel tagged with the requester id. It also flags unsupported op codes and computes the zero flag, because the ALU's own `zero` output is not driven.

## Interface
- `WIDTH`, 48: operand and result width; must match the ALU.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: per-requester request valid; bit i is requester i.
- `req_ready`  out  2: per-requester accept; at most one bit high per cycle.
- `req0_a`, `req0_b`  in  WIDTH each: requester 0 operands.
- `req0_op`  in  4: requester 0 op code.
- `req1_a`, `req1_b`  in  WIDTH each: requester 1 operands.
- `req1_op`  in  4: requester 1 op code.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  1: requester that issued the operation.
- `rsp_result`  out  WIDTH: ALU result; 0 when `rsp_err` is set.
- `rsp_zero`  out  1: high when `rsp_result` == 0.
- `rsp_err`  out  1: op code unsupported.

## Operation
- Supported op codes:
  - 0x0 AND, 0x1 OR, 0x2 ADD, 0x6 SUB
  - 0x7 SLT: unsigned; result is 1 or 0
  - 0xC NOR
  - All other codes are unsupported.
- FSM states and transitions:
  - IDLE: waits for a request.
  - EXEC: one cycle, the ALU registers its result.
  - RESP: holds the response.
  - IDLE → EXEC on accept.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on response handshake with no new accept.
  - RESP → EXEC on response handshake with a same-cycle accept.
- Accept window is `acc_ok` = (state == IDLE) or (state == RESP and `rsp_ready`).
- `req_ready[i]` = `acc_ok` and `grant == i`. The `rsp_ready` → `req_ready` path is combinational.
- Grant rules:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester selected by priority pointer `ptr` is granted.
  - When neither is valid, `grant` follows `ptr`, so `req_ready` may be high with no transfer.
  - After each accepted request, `ptr` becomes the other requester; otherwise it holds.
- On accept:
  - Operands, op and id are loaded into `op_a`, `op_b`, `op_code`, `op_id`.
  - `err_q` = (op is unsupported).
  - The ALU inputs are driven only from these registers, which hold steady through EXEC and RESP so the ALU result stays stable.
- Unsupported op: the ALU is still driven, but `rsp_result` is forced to 0, `rsp_err` = 1 and `rsp_zero` = 1.
- ADD and SUB wrap modulo 2^WIDTH; no carry or overflow is reported.
- Reset state:
  - state IDLE, `ptr` = 0
  - `op_a` = `op_b` = 0, `op_code` = 0x0, `op_id` = 0, `err_q` = 0
  - outputs: `rsp_valid` = 0, `rsp_err` = 0, `rsp_id` = 0
- Reset mid-operation drops the in-flight op; no response is produced for it.

## Timing
- Accept in cycle T → EXEC in T+1 → `rsp_valid` high from T+2.
- `rsp_valid` stays high, with `rsp_*` stable, until `rsp_ready` is sampled high.
- Back-to-back: if the response handshake and the next accept both happen in cycle R, `rsp_valid` is 0 in R+1 and the new response is valid in R+2.
- Peak throughput is one operation per 2 cycles.
- `req_ready` is 0 in EXEC and in RESP while `rsp_ready` is 0.
- With both requesters continuously valid, grants alternate 0, 1, 0, 1, …

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WIDTH` = 48
  - op-code constants: `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`, `OP_NOR`
  - function `op_supported`
  - arbiter state enum {IDLE, EXEC, RESP}
- Sub-module: one instance of the existing `alu`, clocked by `clk`. Its `zero` output is left unconnected.
- Arbiter logic is flat; no further sub-modules.

## Test plan
- Single request: req0 ADD a=0x000000000005, b=0x000000000003, accepted at T → at T+2 `rsp_valid` = 1, `rsp_id` = 0, `rsp_result` = 0x8, `rsp_zero` = 0, `rsp_err` = 0.
- Wrap and compare:
  - SUB 0x0 − 0x1 → 0xFFFFFFFFFFFF.
  - SLT 0x2 < 0x3 → 0x1, `rsp_zero` = 0.
  - AND 0xF0 & 0x0F → 0x0, `rsp_zero` = 1.
- Contention: both requesters valid continuously with 4 ops each, `rsp_ready` = 1 → `rsp_id` sequence 0, 1, 0, 1, …, one response every 2 cycles.
- Backpressure: `rsp_ready` = 0 for 5 cycles after `rsp_valid` rises → `rsp_*` held stable and `req_ready` = 0 throughout; then `rsp_ready` = 1 with req1 valid → handshake and accept in the same cycle.
- Unsupported op 0x3, a=0x5, b=0x5 → `rsp_err` = 1, `rsp_result` = 0, `rsp_zero` = 1.
- Reset asserted during EXEC → next cycle: state IDLE, `rsp_valid` = 0, `ptr` = 0; the dropped op never produces a response.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter/sequencer.
// Holds the datapath width, op codes, op filter and FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 48;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_NOR = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD,
            OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the response
// consumer and the ALU arbiter.
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
);

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    // Requesters and response consumer.
    modport master (
        output req_valid, req0_a, req0_b, req0_op,
        output req1_a, req1_b, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  rsp_result, rsp_zero, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req0_a, req0_b, req0_op,
        input  req1_a, req1_b, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu.sv
// Shared registered ALU: result appears one clock after inputs.
// Its zero output is not computed; users derive it themselves.
module alu import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_result;

    // Register the operation result every cycle.
    always_ff @(posedge clk) begin
        case (i_op)
            OP_AND:  r_result <= i_a & i_b;
            OP_OR:   r_result <= i_a | i_b;
            OP_ADD:  r_result <= i_a + i_b;
            OP_SUB:  r_result <= i_a - i_b;
            OP_SLT:  r_result <= {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_NOR:  r_result <= ~(i_a | i_b);
            default: r_result <= '0;
        endcase
    end

    assign o_result = r_result;
    assign o_zero   = 1'b0;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared ALU.
// One op in flight; response is tagged with the requester id.
module alu_arbiter import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic             r_ptr;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [3:0]       r_op_code;
    logic             r_op_id;
    logic             r_err_q;

    logic             w_acc_ok;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_zero_unused;
    logic [WIDTH-1:0] w_rsp_result;

    // Grant: a lone requester wins, otherwise the pointer decides.
    always_comb begin
        w_grant = r_ptr;
        case (bus.req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            default: w_grant = r_ptr;
        endcase
    end

    assign w_acc_ok = (r_state == IDLE) ||
                      ((r_state == RESP) && bus.rsp_ready);
    assign w_accept = w_acc_ok && bus.req_valid[w_grant];

    assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;
    assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: accept starts EXEC, EXEC always lands in RESP.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = EXEC;
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = w_accept ? EXEC : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the granted op and flip priority on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= OP_AND;
            r_op_id   <= 1'b0;
            r_err_q   <= 1'b0;
        end else if (w_accept) begin
            r_ptr     <= ~w_grant;
            r_op_a    <= w_sel_a;
            r_op_b    <= w_sel_b;
            r_op_code <= w_sel_op;
            r_op_id   <= w_grant;
            r_err_q   <= ~op_supported(w_sel_op);
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .clk      (clk),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .i_op     (r_op_code),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero_unused)
    );

    assign w_rsp_result  = r_err_q ? '0 : w_alu_result;

    assign bus.req_ready  = w_acc_ok ? (w_grant ? 2'b10 : 2'b01)
                                     : 2'b00;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_op_id;
    assign bus.rsp_result = w_rsp_result;
    assign bus.rsp_zero   = (w_rsp_result == '0);
    assign bus.rsp_err    = r_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases plus random
// traffic checked against a transaction-level reference model.
module tb_alu_arbiter;

    typedef struct {
        logic [3:0]  op;
        logic [47:0] a;
        logic [47:0] b;
        int          gap;
    } req_t;

    typedef struct {
        logic        id;
        logic [47:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    logic rr;
    logic rr_man;
    int   mode;

    int total;
    int bad;
    int cyc;

    exp_t q[$];
    bit   busy;
    int   due;
    bit   mptr;

    int          n_rsp;
    logic        last_id;
    logic [47:0] last_res;
    logic        last_zero;
    logic        last_err;
    int          id_log[$];
    int          cyc_log[$];

    alu_arbiter_if bus ();

    alu_arbiter #(.WIDTH(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_model(input bit id, input logic [3:0] op,
                                       input logic [47:0] a,
                                       input logic [47:0] b);
        longint unsigned x;
        longint unsigned y;
        longint unsigned m;
        longint unsigned r;
        exp_t e;
        x = a;
        y = b;
        m = (64'd1 << 48) - 1;
        r = 0;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: r = (x + y) & m;
            4'h6: r = (x - y) & m;
            4'h7: r = (x < y) ? 1 : 0;
            4'hC: r = ~(x | y) & m;
            default: begin
                e.err = 1'b1;
                r = 0;
            end
        endcase
        e.res  = r[47:0];
        e.zero = (r == 0);
        return e;
    endfunction

    // Per-requester drivers: hold a request until it is taken.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rq
        logic        v;
        logic [47:0] a;
        logic [47:0] b;
        logic [3:0]  op;
        req_t        pend[$];
        initial begin
            bit   acc;
            req_t it;
            v  = 1'b0;
            a  = '0;
            b  = '0;
            op = '0;
            forever begin
                @(negedge clk);
                acc = v && bus.req_ready[gi] && !rst;
                @(posedge clk);
                #1;
                if (acc) v = 1'b0;
                if (!v && pend.size() > 0) begin
                    it = pend[0];
                    if (it.gap > 0) begin
                        it.gap = it.gap - 1;
                        pend[0] = it;
                    end else begin
                        it = pend.pop_front();
                        v  = 1'b1;
                        a  = it.a;
                        b  = it.b;
                        op = it.op;
                    end
                end
            end
        end
    end

    assign bus.req_valid = {g_rq[1].v, g_rq[0].v};
    assign bus.req0_a    = g_rq[0].a;
    assign bus.req0_b    = g_rq[0].b;
    assign bus.req0_op   = g_rq[0].op;
    assign bus.req1_a    = g_rq[1].a;
    assign bus.req1_b    = g_rq[1].b;
    assign bus.req1_op   = g_rq[1].op;
    assign bus.rsp_ready = rr;

    // Response consumer readiness.
    initial begin
        rr = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1)      rr = ($urandom_range(0, 3) != 0);
            else if (mode == 2) rr = rr_man;
            else                rr = 1'b1;
        end
    end

    // Reference model: predicts acceptance, grant and response timing.
    initial begin
        bit       vexp;
        bit       hs;
        bit       ok;
        bit       g;
        logic [1:0] er;
        exp_t     e;
        cyc  = 0;
        busy = 0;
        due  = 0;
        mptr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                busy = 0;
                mptr = 0;
            end else begin
                vexp = busy && (cyc >= due);
                chk("rsp_valid", bus.rsp_valid, vexp);
                hs = vexp && rr;
                ok = !busy || hs;
                if (hs) busy = 0;
                if (bus.req_valid == 2'b10)      g = 1;
                else if (bus.req_valid == 2'b01) g = 0;
                else                             g = mptr;
                er = ok ? (g ? 2'b10 : 2'b01) : 2'b00;
                chk("req_ready", bus.req_ready, er);
                if (ok && bus.req_valid[g]) begin
                    if (g)
                        e = ref_model(1, bus.req1_op, bus.req1_a, bus.req1_b);
                    else
                        e = ref_model(0, bus.req0_op, bus.req0_a, bus.req0_b);
                    q.push_back(e);
                    busy = 1;
                    due  = cyc + 2;
                    mptr = !g;
                end
            end
        end
    end

    // Monitor: compare every presented response against the queue head.
    initial begin
        n_rsp = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    chk("rsp_id", bus.rsp_id, q[0].id);
                    chk("rsp_result", bus.rsp_result, q[0].res);
                    chk("rsp_zero", bus.rsp_zero, q[0].zero);
                    chk("rsp_err", bus.rsp_err, q[0].err);
                    if (!bus.rsp_ready) begin
                        chk("stall_req_ready", bus.req_ready, 0);
                    end else begin
                        last_id   = bus.rsp_id;
                        last_res  = bus.rsp_result;
                        last_zero = bus.rsp_zero;
                        last_err  = bus.rsp_err;
                        id_log.push_back(int'(bus.rsp_id));
                        cyc_log.push_back(cyc);
                        n_rsp++;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push(input int i, input logic [3:0] op,
                        input logic [47:0] a, input logic [47:0] b,
                        input int gap);
        req_t it;
        it.op  = op;
        it.a   = a;
        it.b   = b;
        it.gap = gap;
        if (i == 0) g_rq[0].pend.push_back(it);
        else        g_rq[1].pend.push_back(it);
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((g_rq[0].pend.size() > 0 || g_rq[1].pend.size() > 0 ||
                g_rq[0].v || g_rq[1].v || q.size() > 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk("drain_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic one(input int i, input logic [3:0] op,
                       input logic [47:0] a, input logic [47:0] b);
        push(i, op, a, b, 0);
        drain(100);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] tbl [6];
        tbl = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
        if ($urandom_range(0, 4) == 0) return 4'($urandom);
        return tbl[$urandom_range(0, 5)];
    endfunction

    function automatic logic [47:0] rand_val();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) return 48'($urandom_range(0, 3));
        return t[47:0];
    endfunction

    initial begin
        int start;
        int n;
        total  = 0;
        bad    = 0;
        mode   = 0;
        rr_man = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_req_ready", bus.req_ready, 2'b01);

        one(0, 4'h2, 48'h000000000005, 48'h000000000003);
        chk("add_result", last_res, 48'h8);
        chk("add_id", last_id, 0);
        chk("add_zero", last_zero, 0);
        chk("add_err", last_err, 0);

        one(1, 4'h6, 48'h0, 48'h1);
        chk("sub_wrap", last_res, 48'hFFFFFFFFFFFF);
        chk("sub_id", last_id, 1);
        one(0, 4'h7, 48'h2, 48'h3);
        chk("slt_result", last_res, 48'h1);
        chk("slt_zero", last_zero, 0);
        one(1, 4'h0, 48'hF0, 48'h0F);
        chk("and_result", last_res, 48'h0);
        chk("and_zero", last_zero, 1);
        one(0, 4'h3, 48'h5, 48'h5);
        chk("bad_op_err", last_err, 1);
        chk("bad_op_result", last_res, 48'h0);
        chk("bad_op_zero", last_zero, 1);

        // Contention: both requesters valid continuously.
        id_log.delete();
        cyc_log.delete();
        start = int'(mptr);
        for (int k = 0; k < 4; k++) begin
            push(0, 4'h2, rand_val(), rand_val(), 0);
            push(1, 4'h1, rand_val(), rand_val(), 0);
        end
        drain(200);
        chk("cont_count", id_log.size(), 8);
        for (int k = 0; k < id_log.size(); k++)
            chk("cont_id", id_log[k], (start + k) % 2);
        for (int k = 1; k < cyc_log.size(); k++)
            chk("cont_spacing", cyc_log[k] - cyc_log[k-1], 2);

        // Backpressure, then handshake and accept in one cycle.
        mode   = 2;
        rr_man = 1'b0;
        push(0, 4'h6, 48'h123456789ABC, 48'h000000000ABC, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 20);
        chk("bp_rsp_seen", bus.rsp_valid, 1);
        push(1, 4'hC, 48'h0, 48'hFFFF00000000, 0);
        repeat (5) @(negedge clk);
        rr_man = 1'b1;
        @(negedge clk);
        chk("bp_rsp_valid_at_release", bus.rsp_valid, 1);
        chk("bp_same_cycle_accept", bus.req_ready & bus.req_valid, 2'b10);
        mode = 0;
        drain(100);

        // Reset while the op sits in EXEC.
        n0_accept_then_reset();
        @(negedge clk);
        chk("rst_exec_rsp_valid", bus.rsp_valid, 0);
        chk("rst_exec_ptr", bus.req_ready, 2'b01);
        id_log.delete();
        push(0, 4'h1, 48'h1, 48'h2, 0);
        push(1, 4'h1, 48'h3, 48'h4, 0);
        drain(100);
        chk("rst_exec_first_id", id_log.size() > 0 ? id_log[0] : -1, 0);
        chk("rst_exec_count", id_log.size(), 2);

        // Random traffic with random backpressure.
        mode = 1;
        for (int k = 0; k < 60; k++) begin
            push(0, rand_op(), rand_val(), rand_val(), $urandom_range(0, 3));
            push(1, rand_op(), rand_val(), rand_val(), $urandom_range(0, 3));
        end
        drain(5000);
        mode = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic n0_accept_then_reset();
        int n;
        mode = 0;
        push(0, 4'h2, 48'h7, 48'h9, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(g_rq[0].v && bus.req_ready[0]) && n < 20);
        chk("rst_exec_accept_seen", bus.req_ready[0] & g_rq[0].v, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

endmodule
